// File: rtl/a51_pkg.sv
// Shared definitions for the A5/1 cipher streaming path: state encoding,
// default message width and the ASCII offsets used for hex display.
package a51_pkg;

   localparam int A51_DATA_WIDTH = 128;

   // '0' for 0-9; 'A' - 10 so that 4'hA maps straight onto 'A'.
   localparam logic [7:0] ASCII_DIGIT_OFS = 8'h30;
   localparam logic [7:0] ASCII_ALPHA_OFS = 8'h37;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_LATCH,
      ST_EMIT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/cipher_streamer_if.sv
// Character channel from the cipher streamer to the LCD writer:
// valid/ready handshake carrying one ASCII character per transfer.
interface cipher_streamer_if;

   logic [7:0] char_out;
   logic       char_valid;
   logic       char_ready;

   modport master (output char_out, output char_valid, input char_ready);
   modport slave  (input char_out, input char_valid, output char_ready);

endinterface

// File: rtl/hextoascii.sv
// Combinational nibble to upper-case ASCII hex digit conversion.
module hextoascii
   import a51_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   always_comb begin
      if (nibble < 4'd10) ascii = ASCII_DIGIT_OFS + {4'h0, nibble};
      else                ascii = ASCII_ALPHA_OFS + {4'h0, nibble};
   end

endmodule

// File: rtl/cipher_streamer.sv
// Collects DATA_WIDTH keystream bits, XORs them with the stored message and
// streams the result to the LCD as hex characters, most significant first.
module cipher_streamer
   import a51_pkg::*;
#(
   parameter  int DATA_WIDTH = A51_DATA_WIDTH,
   localparam int NIBBLES    = DATA_WIDTH / 4
) (
   input  logic                  clk,
   input  logic                  clrn,
   input  logic                  start,
   input  logic                  ks_bit,
   input  logic                  ks_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   cipher_streamer_if.master     lcd,
   output logic                  busy,
   output logic                  done,
   output logic                  ks_overrun
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   state_t                  state_q,  state_d;
   logic [DATA_WIDTH-1:0]   shift_q,  shift_d;
   logic [DATA_WIDTH-1:0]   cipher_q, cipher_d;
   logic [CNT_W-1:0]        cnt_q,    cnt_d;
   logic [IDX_W-1:0]        idx_q,    idx_d;
   logic                    ovr_q,    ovr_d;
   logic [3:0]              nibble;
   logic [7:0]              ascii;

   // NOTE: every next-state signal takes its hold value first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cipher_d = cipher_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      ovr_d    = ovr_q;

      if (start) begin
         // A restart discards whatever ks_bit arrives alongside it.
         state_d = ST_COLLECT;
         shift_d = '0;
         cnt_d   = '0;
         ovr_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_COLLECT: begin
               if (ks_valid) begin
                  shift_d = {shift_q[DATA_WIDTH-2:0], ks_bit};
                  cnt_d   = cnt_q + 1'b1;
                  state_d = (cnt_d == CNT_FULL) ? ST_LATCH : ST_COLLECT;
               end
            end
            ST_LATCH: begin
               cipher_d = shift_q ^ data_in;
               idx_d    = IDX_LAST;
               state_d  = ST_EMIT;
            end
            ST_EMIT: begin
               if (lcd.char_ready) begin
                  if (idx_q == '0) state_d = ST_DONE;
                  else             idx_d   = idx_q - 1'b1;
               end
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
         endcase

         if (ks_valid && (state_q inside {ST_LATCH, ST_EMIT, ST_DONE}))
            ovr_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; the shift and
   // cipher registers are plain flops, so the async reset clears them too.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q  <= ST_IDLE;
         shift_q  <= '0;
         cipher_q <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cipher_q <= cipher_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         ovr_q    <= ovr_d;
      end
   end

   assign nibble = cipher_q[4*idx_q +: 4];

   hextoascii u_hex (
      .nibble (nibble),
      .ascii  (ascii)
   );

   // char_out is forced to zero outside EMIT so reset and idle read as blank.
   assign lcd.char_valid = (state_q == ST_EMIT);
   assign lcd.char_out   = lcd.char_valid ? ascii : 8'h00;
   assign busy           = state_q inside {ST_COLLECT, ST_LATCH, ST_EMIT};
   assign done           = (state_q == ST_DONE);
   assign ks_overrun     = ovr_q;

endmodule

// File: tb/tb_cipher_streamer.sv
// Directed self-checking bench for cipher_streamer: full encrypt/emit runs,
// stalls, keystream gaps, restart, overrun and mid-emit reset.
module tb_cipher_streamer;

   logic         clk;
   logic         clrn;
   logic         start;
   logic         ks_bit;
   logic         ks_valid;
   logic [127:0] data_in;
   logic         busy;
   logic         done;
   logic         ks_overrun;

   int n_vec = 0;
   int n_err = 0;

   cipher_streamer_if lcd ();

   cipher_streamer dut (
      .clk        (clk),
      .clrn       (clrn),
      .start      (start),
      .ks_bit     (ks_bit),
      .ks_valid   (ks_valid),
      .data_in    (data_in),
      .lcd        (lcd),
      .busy       (busy),
      .done       (done),
      .ks_overrun (ks_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [127:0] P1 = 128'hDEADBEEF_0BADF00D_CAFEBABE_13579BDF;
   localparam logic [127:0] D1 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
   localparam logic [127:0] P2 = 128'h0123FEDC_89AB7654_A5A55A5A_F00F0FF0;
   localparam logic [127:0] D2 = 128'h11112222_33334444_55556666_77778888;
   localparam logic [127:0] DH = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] PF = 128'h80000000_00000000_00000000_00000000;

   function automatic logic [7:0] asc(input logic [3:0] n);
      if (n < 4'd10) return 8'("0") + 8'(n);
      else           return 8'("A") + 8'(n) - 8'd10;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; leaves the block in COLLECT with the start cycle done.
   task automatic pulse_start(input bit with_ks);
      start    = 1'b1;
      ks_valid = with_ks;
      ks_bit   = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      ks_valid = 1'b0;
   endtask

   // First bit sent lands in bit 127; returns at the negedge where LATCH is active.
   task automatic send(input logic [127:0] pat, input bit gaps);
      for (int i = 0; i < 128; i++) begin
         ks_valid = 1'b1;
         ks_bit   = pat[127-i];
         @(negedge clk);
         if (gaps && ((i + 1) % 10 == 0) && (i < 127)) begin
            ks_valid = 1'b0;
            repeat (3) @(negedge clk);
         end
      end
      ks_valid = 1'b0;
      ks_bit   = 1'b0;
   endtask

   // Entered at the negedge showing index 31; consumes n_chars characters.
   task automatic recv(input string tag, input logic [127:0] exp, input int n_chars, input int stall_idx);
      for (int k = 31; k > 31 - n_chars; k--) begin
         check($sformatf("%s_valid%0d", tag, k), 128'(lcd.char_valid), 128'(1));
         check($sformatf("%s_char%0d", tag, k), 128'(lcd.char_out), 128'(asc(exp[4*k +: 4])));
         if (k == stall_idx) begin
            lcd.char_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               check($sformatf("%s_stall_valid%0d", tag, s), 128'(lcd.char_valid), 128'(1));
               check($sformatf("%s_stall_char%0d", tag, s), 128'(lcd.char_out), 128'(asc(exp[4*k +: 4])));
            end
            lcd.char_ready = 1'b1;
         end
         @(negedge clk);
      end
   endtask

   task automatic full_run(input string tag, input logic [127:0] pat, input logic [127:0] dat,
                           input bit gaps, input int stall_idx);
      data_in = dat;
      send(pat, gaps);
      check({tag, "_latch_valid"}, 128'(lcd.char_valid), 128'(0));
      check({tag, "_latch_busy"}, 128'(busy), 128'(1));
      @(negedge clk);
      recv(tag, pat ^ dat, 32, stall_idx);
      check({tag, "_done"}, 128'(done), 128'(1));
      check({tag, "_done_valid"}, 128'(lcd.char_valid), 128'(0));
      check({tag, "_done_busy"}, 128'(busy), 128'(0));
   endtask

   initial begin
      clrn           = 1'b1;
      start          = 1'b0;
      ks_bit         = 1'b0;
      ks_valid       = 1'b0;
      data_in        = '0;
      lcd.char_ready = 1'b1;

      #2 clrn = 1'b0;
      #1;
      check("rst_char_out", 128'(lcd.char_out), 128'(0));
      check("rst_char_valid", 128'(lcd.char_valid), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_overrun", 128'(ks_overrun), 128'(0));
      @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);
      check("idle_busy", 128'(busy), 128'(0));

      // All-ones keystream over a zero message: every character is 'F'.
      pulse_start(1'b0);
      check("start_busy", 128'(busy), 128'(1));
      full_run("ones", '1, '0, 1'b0, -1);

      // Keystream in DONE is dropped but flagged; DONE holds.
      ks_valid = 1'b1;
      ks_bit   = 1'b1;
      @(negedge clk);
      ks_valid = 1'b0;
      check("ovr_set", 128'(ks_overrun), 128'(1));
      check("ovr_done_hold", 128'(done), 128'(1));

      // Start with a valid bit alongside it: the bit must not be captured.
      pulse_start(1'b1);
      check("ovr_clr", 128'(ks_overrun), 128'(0));
      full_run("hexdata", '0, DH, 1'b0, -1);

      pulse_start(1'b0);
      full_run("firstbit", PF, '0, 1'b0, -1);

      pulse_start(1'b0);
      full_run("nogap", P1, D1, 1'b0, -1);
      pulse_start(1'b0);
      full_run("gapstall", P1, D1, 1'b1, 25);

      // Reset partway through emission, at index 20.
      pulse_start(1'b0);
      data_in = D2;
      send(P2, 1'b0);
      @(negedge clk);
      recv("part", P2 ^ D2, 11, -1);
      check("part_idx20", 128'(lcd.char_out), 128'(asc(((P2 ^ D2) >> 80) & 128'hF)));
      #2 clrn = 1'b0;
      #1;
      check("mid_rst_char_out", 128'(lcd.char_out), 128'(0));
      check("mid_rst_char_valid", 128'(lcd.char_valid), 128'(0));
      check("mid_rst_busy", 128'(busy), 128'(0));
      check("mid_rst_done", 128'(done), 128'(0));
      check("mid_rst_overrun", 128'(ks_overrun), 128'(0));
      @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);
      check("post_rst_busy", 128'(busy), 128'(0));

      // From IDLE a valid bit alone starts collection and is kept.
      full_run("idlecap", P2, D2, 1'b0, -1);

      pulse_start(1'b0);
      full_run("restart", P1 ^ P2, D2, 1'b0, -1);
      ks_valid = 1'b1;
      @(negedge clk);
      ks_valid = 1'b0;
      check("ovr2_set", 128'(ks_overrun), 128'(1));
      @(negedge clk);
      check("ovr2_sticky", 128'(ks_overrun), 128'(1));
      pulse_start(1'b0);
      check("ovr2_clr", 128'(ks_overrun), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
